// File: rtl/psum_buffer.sv
// psum_buffer: address-indexed partial-sum accumulator feeding a small in-order output FIFO.
// Define PSUMBUF_RELU_EN to clamp negative lanes to zero on FIFO push (acc keeps signed values).
module psum_buffer #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 24,
  parameter int LANES      = 4,
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psumEn,
  input  logic                     first,
  input  logic                     last,
  input  logic [5:0]               headAddress,
  input  logic [LANES*DATA_W-1:0]  psumIn,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [LANES*ACC_W-1:0]   outData,
  output logic [5:0]               outAddr,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);

  logic [ACC_W-1:0]        acc [DEPTH];
  logic [ACC_W-1:0]        new_val [LANES];
  logic [AW-1:0]           lane_addr [LANES];
  logic [DATA_W-1:0]       psum_lane;
  logic [LANES*ACC_W-1:0]  push_dat;

  always_comb begin
    push_dat  = '0;
    psum_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_addr[i] = AW'(headAddress) + AW'(i);
      psum_lane    = psumIn[i*DATA_W +: DATA_W];
      new_val[i]   = {{(ACC_W-DATA_W){psum_lane[DATA_W-1]}}, psum_lane};
      if (!first) begin
        new_val[i] = acc[lane_addr[i]] + new_val[i];
      end
`ifdef PSUMBUF_RELU_EN
      push_dat[i*ACC_W +: ACC_W] = new_val[i][ACC_W-1] ? '0 : new_val[i];
`else
      push_dat[i*ACC_W +: ACC_W] = new_val[i];
`endif
    end
  end

  // Lane addresses are distinct (LANES <= DEPTH), so per-lane writes never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < DEPTH; j++) acc[j] <= '0;
    end else if (psumEn) begin
      for (int i = 0; i < LANES; i++) acc[lane_addr[i]] <= new_val[i];
    end
  end

  logic [LANES*ACC_W-1:0] fifo_dat  [FIFO_DEPTH];
  logic [5:0]             fifo_addr [FIFO_DEPTH];
  logic [FW:0]            wr_ptr, rd_ptr;
  logic                   empty, full, pop, push_req, push;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
  assign pop      = !empty && outReady;
  assign push_req = psumEn && last;
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_dat[k]  <= '0;
        fifo_addr[k] <= '0;
      end
    end else begin
      if (push) begin
        fifo_dat[wr_ptr[FW-1:0]]  <= push_dat;
        fifo_addr[wr_ptr[FW-1:0]] <= headAddress;
        wr_ptr                    <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  // Head slot is never rewritten while occupied, so outputs hold steady under backpressure.
  assign outValid = !empty;
  assign outData  = fifo_dat[rd_ptr[FW-1:0]];
  assign outAddr  = fifo_addr[rd_ptr[FW-1:0]];

endmodule
